exec_pipe_stage: RTL and testbench

- Parametrised next-generation CPU execute stage.
- Contains its own register file and NZCV flags, an ALU and branch-condition evaluation.
- Adds three things the single-cycle execute stage lacks:
  - a valid/ready handshake to decode;
  - a stalling request/acknowledge data-memory port with timeout;
  - a configurable branch shadow.
- Sits between the decode stage and external data memory; drives the fetch unit's branch offset.

---
 rtl/exec_pipe_if.sv | 43 ++++
 rtl/exec_pipe_stage.sv | 274 +++++++++++++++++++++++++++
 tb/tb_exec_pipe_stage.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/exec_pipe_if.sv
// Decode/memory/fetch-facing bus of the execute stage.
// master = decode + data memory + fetch side; slave = exec_pipe_stage.
interface exec_pipe_if #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5
);
  localparam int SEL_W = $clog2(NUM_REGS);

  logic              in_valid;
  logic              in_ready;
  logic [4:0]        uop;
  logic              num_to_rhs;
  logic [WIDTH-1:0]  num;
  logic [SEL_W-1:0]  sel_p0;
  logic [SEL_W-1:0]  sel_p1;
  logic [SEL_W-1:0]  sel_in;
  logic [3:0]        branch_cond;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_ack;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_err;
  logic              branch_taken;
  logic [WIDTH-1:0]  branch_offset;
  logic [3:0]        flags;

  modport master (
    output in_valid, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, branch_cond,
           mem_ack, mem_rdata,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_err,
           branch_taken, branch_offset, flags
  );

  modport slave (
    input  in_valid, uop, num_to_rhs, num, sel_p0, sel_p1, sel_in, branch_cond,
           mem_ack, mem_rdata,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_err,
           branch_taken, branch_offset, flags
  );
endinterface

// File: rtl/exec_pipe_stage.sv
// CPU execute stage: register file, NZCV, ALU, branch evaluation, stalling memory port.
// Optional GPIO write uop enabled by defining EXEC_GPIO_EN (adds gpio_state output).
module exec_pipe_stage #(
  parameter int WIDTH         = 32,
  parameter int NUM_REGS      = 16,
  parameter int ADDR_W        = 5,
  parameter int SHADOW_CYCLES = 1,
  parameter int MEM_TIMEOUT   = 15
) (
  input  logic             clk,
  input  logic             rst,
  exec_pipe_if.slave       pipe
`ifdef EXEC_GPIO_EN
  ,
  output logic [WIDTH-1:0] gpio_state
`endif
);
  localparam int SEL_W = $clog2(NUM_REGS);
  localparam int SA_W  = $clog2(WIDTH);
  localparam int SH_W  = (SHADOW_CYCLES > 0) ? $clog2(SHADOW_CYCLES + 1) : 1;
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [4:0] UOP_MOV = 5'd1;
  localparam logic [4:0] UOP_ADD = 5'd2;
  localparam logic [4:0] UOP_SUB = 5'd3;
  localparam logic [4:0] UOP_AND = 5'd4;
  localparam logic [4:0] UOP_ORR = 5'd5;
  localparam logic [4:0] UOP_EOR = 5'd6;
  localparam logic [4:0] UOP_CMP = 5'd7;
  localparam logic [4:0] UOP_LSL = 5'd8;
  localparam logic [4:0] UOP_LSR = 5'd9;
  localparam logic [4:0] UOP_LDR = 5'd10;
  localparam logic [4:0] UOP_STR = 5'd11;
  localparam logic [4:0] UOP_B   = 5'd12;
`ifdef EXEC_GPIO_EN
  localparam logic [4:0] UOP_GPIO = 5'd13;
`endif

  typedef enum logic [1:0] {ST_RUN, ST_MEM_WAIT, ST_SHADOW} state_t;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic [3:0]       nzcv;
    logic             wr;
  } alu_t;

  // Uops that are not ALU ops return wr=0 and the incoming flags untouched.
  function automatic alu_t alu_exec(input logic [4:0]       op,
                                    input logic [WIDTH-1:0] lhs,
                                    input logic [WIDTH-1:0] rhs,
                                    input logic [WIDTH-1:0] sum,
                                    input logic [3:0]       nzcv_in);
    logic [WIDTH:0]          diff;
    logic signed [WIDTH-1:0] lhs_s;
    logic signed [WIDTH-1:0] rhs_s;
    logic signed [WIDTH-1:0] sum_s;
    logic signed [WIDTH-1:0] diff_s;
    alu_t                    r;
    diff   = {1'b0, lhs} - {1'b0, rhs};
    lhs_s  = lhs;
    rhs_s  = rhs;
    sum_s  = sum;
    diff_s = diff[WIDTH-1:0];
    r      = '0;
    r.nzcv = nzcv_in;
    case (op)
      UOP_MOV: begin r.res = rhs; r.wr = 1'b1; end
      UOP_ADD: begin
        r.res  = sum;
        r.wr   = 1'b1;
        r.nzcv = {sum_s < 0, sum == '0, sum < lhs,
                  ((lhs_s < 0) == (rhs_s < 0)) && ((sum_s < 0) != (lhs_s < 0))};
      end
      UOP_SUB, UOP_CMP: begin
        r.res  = diff[WIDTH-1:0];
        r.wr   = (op == UOP_SUB);
        r.nzcv = {diff_s < 0, diff[WIDTH-1:0] == '0, ~diff[WIDTH],
                  ((lhs_s < 0) != (rhs_s < 0)) && ((diff_s < 0) != (lhs_s < 0))};
      end
      UOP_AND: begin r.res = lhs & rhs; r.wr = 1'b1; end
      UOP_ORR: begin r.res = lhs | rhs; r.wr = 1'b1; end
      UOP_EOR: begin r.res = lhs ^ rhs; r.wr = 1'b1; end
      UOP_LSL: begin r.res = lhs << rhs[SA_W-1:0]; r.wr = 1'b1; end
      UOP_LSR: begin r.res = lhs >> rhs[SA_W-1:0]; r.wr = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    {n, z, c, v} = nzcv;
    case (cond)
      4'h0:    return z;
      4'h1:    return !z;
      4'h2:    return c;
      4'h3:    return !c;
      4'h4:    return n;
      4'h5:    return !n;
      4'h6:    return v;
      4'h7:    return !v;
      4'h8:    return c && !z;
      4'h9:    return !c || z;
      4'hA:    return n == v;
      4'hB:    return n != v;
      4'hC:    return !z && (n == v);
      4'hD:    return z || (n != v);
      4'hE:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  regs_q [NUM_REGS];
  logic [WIDTH-1:0]  regs_d [NUM_REGS];
  logic [3:0]        flags_q, flags_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
  logic              mem_err_q, mem_err_d;
  logic              br_taken_q, br_taken_d;
  logic [WIDTH-1:0]  br_off_q, br_off_d;
  logic [SH_W-1:0]   shadow_q, shadow_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [SEL_W-1:0]  ld_dst_q, ld_dst_d;
`ifdef EXEC_GPIO_EN
  logic [WIDTH-1:0]  gpio_q, gpio_d;
`endif

  logic [WIDTH-1:0]  lhs, rhs, sum;
  logic              in_ready;
  alu_t              alu_r;

  assign in_ready = (state_q != ST_MEM_WAIT);
  assign lhs      = regs_q[pipe.sel_p1];
  assign rhs      = pipe.num_to_rhs ? pipe.num : regs_q[pipe.sel_p0];
  assign sum      = lhs + rhs;
  assign alu_r    = alu_exec(pipe.uop, lhs, rhs, sum, flags_q);

  always_comb begin
    state_d     = state_q;
    regs_d      = regs_q;
    flags_d     = flags_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_err_d   = 1'b0;
    br_taken_d  = 1'b0;
    br_off_d    = '0;
    shadow_d    = shadow_q;
    tmo_d       = tmo_q;
    ld_dst_d    = ld_dst_q;
`ifdef EXEC_GPIO_EN
    gpio_d      = gpio_q;
`endif
    case (state_q)
      ST_RUN: begin
        if (pipe.in_valid) begin
          if (alu_r.wr) regs_d[pipe.sel_in] = alu_r.res;
          flags_d = alu_r.nzcv;
          case (pipe.uop)
            UOP_LDR, UOP_STR: begin
              mem_req_d   = 1'b1;
              mem_we_d    = (pipe.uop == UOP_STR);
              mem_addr_d  = sum[ADDR_W-1:0];
              mem_wdata_d = regs_q[pipe.sel_p0];
              ld_dst_d    = pipe.sel_in;
              tmo_d       = '0;
              state_d     = ST_MEM_WAIT;
            end
            UOP_B: begin
              if (cond_pass(pipe.branch_cond, flags_q)) begin
                br_taken_d = 1'b1;
                br_off_d   = pipe.num;
                if (SHADOW_CYCLES > 0) begin
                  shadow_d = SH_W'(SHADOW_CYCLES);
                  state_d  = ST_SHADOW;
                end
              end
            end
`ifdef EXEC_GPIO_EN
            UOP_GPIO: begin
              if (sum == '0) gpio_d = regs_q[pipe.sel_p0];
            end
`endif
            default: ;
          endcase
        end
      end
      // An ack on the final wait cycle still completes the access.
      ST_MEM_WAIT: begin
        if (pipe.mem_ack) begin
          if (!mem_we_q) regs_d[ld_dst_q] = pipe.mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          tmo_d     = '0;
          state_d   = ST_RUN;
        end else if (tmo_q == TMO_W'(MEM_TIMEOUT - 1)) begin
          mem_err_d = 1'b1;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          tmo_d     = '0;
          state_d   = ST_RUN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_SHADOW: begin
        if (pipe.in_valid) begin
          if (shadow_q <= SH_W'(1)) begin
            shadow_d = '0;
            state_d  = ST_RUN;
          end else begin
            shadow_d = shadow_q - SH_W'(1);
          end
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      flags_q     <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_err_q   <= 1'b0;
      br_taken_q  <= 1'b0;
      br_off_q    <= '0;
      shadow_q    <= '0;
      tmo_q       <= '0;
      ld_dst_q    <= '0;
`ifdef EXEC_GPIO_EN
      gpio_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      regs_q      <= regs_d;
      flags_q     <= flags_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_err_q   <= mem_err_d;
      br_taken_q  <= br_taken_d;
      br_off_q    <= br_off_d;
      shadow_q    <= shadow_d;
      tmo_q       <= tmo_d;
      ld_dst_q    <= ld_dst_d;
`ifdef EXEC_GPIO_EN
      gpio_q      <= gpio_d;
`endif
    end
  end

  assign pipe.in_ready      = in_ready;
  assign pipe.mem_req       = mem_req_q;
  assign pipe.mem_we        = mem_we_q;
  assign pipe.mem_addr      = mem_addr_q;
  assign pipe.mem_wdata     = mem_wdata_q;
  assign pipe.mem_err       = mem_err_q;
  assign pipe.branch_taken  = br_taken_q;
  assign pipe.branch_offset = br_off_q;
  assign pipe.flags         = flags_q;
`ifdef EXEC_GPIO_EN
  assign gpio_state         = gpio_q;
`endif
endmodule

// File: tb/tb_exec_pipe_stage.sv
// Directed bench for exec_pipe_stage: ALU vector table plus memory, timeout, branch and reset sequences.
// Registers are observed architecturally by storing them and checking mem_wdata.
module tb_exec_pipe_stage;
  localparam int MEM_TIMEOUT = 15;
  localparam logic [4:0] U_NOP = 5'd0, U_MOV = 5'd1, U_ADD = 5'd2, U_SUB = 5'd3,
                         U_AND = 5'd4, U_ORR = 5'd5, U_EOR = 5'd6, U_CMP = 5'd7,
                         U_LSL = 5'd8, U_LSR = 5'd9, U_LDR = 5'd10, U_STR = 5'd11,
                         U_B = 5'd12, U_GPIO = 5'd13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  exec_pipe_if #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(5)) pipe ();

`ifdef EXEC_GPIO_EN
  logic [31:0] gpio_state;
`endif

  exec_pipe_stage #(.WIDTH(32), .NUM_REGS(16), .ADDR_W(5), .SHADOW_CYCLES(1),
                    .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .pipe(pipe)
`ifdef EXEC_GPIO_EN
    ,
    .gpio_state(gpio_state)
`endif
  );

  typedef struct {
    logic [4:0]  uop;
    logic        ntr;
    logic [31:0] num;
    int          p0;
    int          p1;
    int          dst;
    logic [31:0] ev;
    logic [3:0]  ef;
  } vec_t;

  typedef struct {
    logic [3:0] cond;
    logic       taken;
  } bvec_t;

  vec_t  vecs[16];
  bvec_t bvecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [4:0] u, input logic ntr, input logic [31:0] n,
                       input int p0, input int p1, input int d, input logic [3:0] c);
    pipe.in_valid    = 1'b1;
    pipe.uop         = u;
    pipe.num_to_rhs  = ntr;
    pipe.num         = n;
    pipe.sel_p0      = 4'(p0);
    pipe.sel_p1      = 4'(p1);
    pipe.sel_in      = 4'(d);
    pipe.branch_cond = c;
    @(posedge clk); #1;
    pipe.in_valid    = 1'b0;
  endtask

  task automatic read_reg(input int r, input logic [31:0] exp, input string nm);
    issue(U_STR, 1'b1, 32'h0, r, r, 0, 4'hE);
    check(nm, pipe.mem_wdata, exp);
    pipe.mem_ack = 1'b1;
    @(posedge clk); #1;
    pipe.mem_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    pipe.in_valid = 0; pipe.uop = 0; pipe.num_to_rhs = 0; pipe.num = 0;
    pipe.sel_p0 = 0; pipe.sel_p1 = 0; pipe.sel_in = 0; pipe.branch_cond = 0;
    pipe.mem_ack = 0; pipe.mem_rdata = 0;

    //               uop    ntr  num           p0 p1 dst exp value     NZCV
    vecs[0]  = '{U_MOV, 1'b1, 32'd5,        0, 0, 1,  32'd5,        4'b0000};
    vecs[1]  = '{U_ADD, 1'b1, 32'hFFFFFFFB, 0, 1, 2,  32'h0,        4'b0110};
    vecs[2]  = '{U_SUB, 1'b1, 32'd7,        0, 1, 3,  32'hFFFFFFFE, 4'b1000};
    vecs[3]  = '{U_MOV, 1'b1, 32'h7FFFFFFF, 0, 0, 5,  32'h7FFFFFFF, 4'b1000};
    vecs[4]  = '{U_ADD, 1'b1, 32'd1,        0, 5, 6,  32'h80000000, 4'b1001};
    vecs[5]  = '{U_AND, 1'b0, 32'h0,        1, 5, 7,  32'd5,        4'b1001};
    vecs[6]  = '{U_ORR, 1'b1, 32'hF0,       0, 1, 7,  32'hF5,       4'b1001};
    vecs[7]  = '{U_EOR, 1'b1, 32'hFF,       0, 7, 8,  32'h0A,       4'b1001};
    vecs[8]  = '{U_LSL, 1'b1, 32'd4,        0, 1, 9,  32'h50,       4'b1001};
    vecs[9]  = '{U_LSR, 1'b1, 32'h3F,       0, 6, 10, 32'h1,        4'b1001};
    vecs[10] = '{U_SUB, 1'b1, 32'd1,        0, 6, 12, 32'h7FFFFFFF, 4'b0011};
    vecs[11] = '{U_CMP, 1'b1, 32'd5,        0, 1, 11, 32'h0,        4'b0110};
    vecs[12] = '{U_ADD, 1'b0, 32'h0,        5, 5, 9,  32'hFFFFFFFE, 4'b1001};
    vecs[13] = '{U_NOP, 1'b1, 32'h1234,     0, 0, 1,  32'd5,        4'b1001};
    vecs[14] = '{5'd20, 1'b1, 32'h1234,     0, 0, 1,  32'd5,        4'b1001};
    vecs[15] = '{U_GPIO,1'b1, 32'h99,       0, 0, 1,  32'd5,        4'b1001};

    // flags after CMP 5,7: N=1 Z=0 C=0 V=0
    bvecs[0]  = '{4'hB, 1'b1}; bvecs[1] = '{4'hA, 1'b0}; bvecs[2]  = '{4'h3, 1'b1};
    bvecs[3]  = '{4'h8, 1'b0}; bvecs[4] = '{4'h4, 1'b1}; bvecs[5]  = '{4'h5, 1'b0};
    bvecs[6]  = '{4'h6, 1'b0}; bvecs[7] = '{4'hD, 1'b1}; bvecs[8]  = '{4'hC, 1'b0};
    bvecs[9]  = '{4'hE, 1'b1}; bvecs[10] = '{4'h0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    check("rst_flags", pipe.flags, 4'h0);
    check("rst_mem_req", pipe.mem_req, 1'b0);
    check("rst_in_ready", pipe.in_ready, 1'b1);
    check("rst_branch_taken", pipe.branch_taken, 1'b0);
    check("rst_branch_offset", pipe.branch_offset, 32'h0);
    check("rst_mem_err", pipe.mem_err, 1'b0);
    check("rst_mem_wdata", pipe.mem_wdata, 32'h0);

    for (int i = 0; i < 16; i++) begin
      issue(vecs[i].uop, vecs[i].ntr, vecs[i].num, vecs[i].p0, vecs[i].p1, vecs[i].dst, 4'hE);
      check($sformatf("vec%0d_flags", i), pipe.flags, vecs[i].ef);
      read_reg(vecs[i].dst, vecs[i].ev, $sformatf("vec%0d_reg", i));
    end

    // STR r1 -> addr 3, ack in the 4th wait cycle; decode keeps offering MOV r13
    issue(U_STR, 1'b1, 32'd3, 1, 0, 0, 4'hE);
    check("str_req", pipe.mem_req, 1'b1);
    check("str_we", pipe.mem_we, 1'b1);
    check("str_addr", pipe.mem_addr, 5'd3);
    check("str_wdata", pipe.mem_wdata, 32'd5);
    check("str_in_ready", pipe.in_ready, 1'b0);
    pipe.in_valid = 1'b1; pipe.uop = U_MOV; pipe.num_to_rhs = 1'b1;
    pipe.num = 32'd77; pipe.sel_in = 4'd13;
    ok = 1'b1;
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      ok &= pipe.mem_req && !pipe.in_ready && (pipe.mem_addr == 5'd3) && (pipe.mem_wdata == 32'd5);
      if (k == 4) pipe.mem_ack = 1'b1;
    end
    check("str_wait_hold", ok, 1'b1);
    @(posedge clk); #1;
    pipe.mem_ack = 1'b0; pipe.in_valid = 1'b0;
    check("str_done_req", pipe.mem_req, 1'b0);
    check("str_done_ready", pipe.in_ready, 1'b1);
    read_reg(13, 32'h0, "mem_wait_no_accept");

    issue(U_LDR, 1'b1, 32'd3, 0, 0, 3, 4'hE);
    check("ldr_we", pipe.mem_we, 1'b0);
    check("ldr_addr", pipe.mem_addr, 5'd3);
    pipe.mem_ack = 1'b1; pipe.mem_rdata = 32'd5;
    @(posedge clk); #1;
    pipe.mem_ack = 1'b0; pipe.mem_rdata = 32'h0;
    read_reg(3, 32'd5, "ldr_r3");

    // LDR with no ack: timeout
    issue(U_LDR, 1'b1, 32'd1, 0, 0, 3, 4'hE);
    ok = 1'b1;
    for (int k = 1; k <= MEM_TIMEOUT; k++) begin
      ok &= pipe.mem_req && !pipe.mem_err && !pipe.in_ready;
      @(posedge clk); #1;
    end
    check("tmo_wait_hold", ok, 1'b1);
    check("tmo_err_pulse", pipe.mem_err, 1'b1);
    check("tmo_req_drop", pipe.mem_req, 1'b0);
    check("tmo_in_ready", pipe.in_ready, 1'b1);
    @(posedge clk); #1;
    check("tmo_err_one_cycle", pipe.mem_err, 1'b0);
    read_reg(3, 32'd5, "tmo_r3_unchanged");

    // ack on the timeout cycle wins
    issue(U_LDR, 1'b1, 32'd2, 0, 0, 14, 4'hE);
    for (int k = 1; k < MEM_TIMEOUT; k++) begin
      @(posedge clk); #1;
    end
    check("ack15_still_req", pipe.mem_req, 1'b1);
    pipe.mem_ack = 1'b1; pipe.mem_rdata = 32'hCAFE0001;
    @(posedge clk); #1;
    pipe.mem_ack = 1'b0; pipe.mem_rdata = 32'h0;
    check("ack15_no_err", pipe.mem_err, 1'b0);
    check("ack15_req_drop", pipe.mem_req, 1'b0);
    read_reg(14, 32'hCAFE0001, "ack15_r14");

    // taken branch and its shadow
    issue(U_CMP, 1'b1, 32'd5, 0, 1, 0, 4'hE);
    check("cmp_eq_flags", pipe.flags, 4'b0110);
    issue(U_B, 1'b1, 32'hFFFFFFF8, 0, 0, 0, 4'h0);
    check("beq_taken", pipe.branch_taken, 1'b1);
    check("beq_offset", pipe.branch_offset, 32'hFFFFFFF8);
    @(posedge clk); #1;
    check("beq_pulse_end", pipe.branch_taken, 1'b0);
    check("beq_offset_clear", pipe.branch_offset, 32'h0);
    check("shadow_in_ready", pipe.in_ready, 1'b1);
    issue(U_MOV, 1'b1, 32'd9, 0, 0, 4, 4'hE);
    read_reg(4, 32'h0, "shadow_discard_r4");
    issue(U_MOV, 1'b1, 32'd9, 0, 0, 4, 4'hE);
    read_reg(4, 32'd9, "after_shadow_r4");

    issue(U_B, 1'b1, 32'h40, 0, 0, 0, 4'h1);
    check("bne_not_taken", pipe.branch_taken, 1'b0);
    issue(U_MOV, 1'b1, 32'd3, 0, 0, 15, 4'hE);
    read_reg(15, 32'd3, "bne_no_shadow_r15");
    issue(U_B, 1'b1, 32'h44, 0, 0, 0, 4'hF);
    check("bnv_not_taken", pipe.branch_taken, 1'b0);

    issue(U_CMP, 1'b1, 32'd7, 0, 1, 0, 4'hE);
    check("cmp_lt_flags", pipe.flags, 4'b1000);
    for (int i = 0; i < 11; i++) begin
      issue(U_B, 1'b1, 32'h100 + 32'(i), 0, 0, 0, bvecs[i].cond);
      check($sformatf("bcond%0h_taken", bvecs[i].cond), pipe.branch_taken, bvecs[i].taken);
      check($sformatf("bcond%0h_offset", bvecs[i].cond), pipe.branch_offset,
            bvecs[i].taken ? 32'h100 + 32'(i) : 32'h0);
      if (bvecs[i].taken) issue(U_NOP, 1'b0, 32'h0, 0, 0, 0, 4'hE);
    end

    // asynchronous reset in the middle of a memory wait
    issue(U_STR, 1'b1, 32'h0, 1, 0, 0, 4'hE);
    check("rstw_req_before", pipe.mem_req, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstw_req_drop", pipe.mem_req, 1'b0);
    check("rstw_flags", pipe.flags, 4'h0);
    check("rstw_in_ready", pipe.in_ready, 1'b1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("rstw_ready_after", pipe.in_ready, 1'b1);
    read_reg(1, 32'h0, "rstw_r1");
    read_reg(15, 32'h0, "rstw_r15");

`ifdef EXEC_GPIO_EN
    check("gpio_reset", gpio_state, 32'h0);
    issue(U_MOV, 1'b1, 32'hA5, 0, 0, 5, 4'hE);
    issue(U_GPIO, 1'b1, 32'h0, 5, 0, 0, 4'hE);
    check("gpio_addr0", gpio_state, 32'hA5);
    issue(U_MOV, 1'b1, 32'h3C, 0, 0, 6, 4'hE);
    issue(U_GPIO, 1'b1, 32'h1, 6, 0, 0, 4'hE);
    check("gpio_addr1_ignored", gpio_state, 32'hA5);
    issue(U_B, 1'b1, 32'h8, 0, 0, 0, 4'hE);
    issue(U_GPIO, 1'b1, 32'h0, 6, 0, 0, 4'hE);
    check("gpio_shadow_discard", gpio_state, 32'hA5);
    issue(U_GPIO, 1'b1, 32'h0, 6, 0, 0, 4'hE);
    check("gpio_after_shadow", gpio_state, 32'h3C);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
